imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Boot-time program loader: the writer side of the instruction memory that the pipelined CPU reads.
//  - Accepts a byte stream over a valid/ready handshake.
//  - Assembles 16-bit instruction words and writes them into IMem through its wen/addr/data_in port.
//  - Holds the CPU (cpu_hold) until the image is fully written; the top muxes the IMem port between loader and PC.
// PARAMETERS
//  BASE_ADDR  16'h0000  IMem address of the first loaded word
//  DEPTH      16'd256   max words accepted; larger length field -> error
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst        in   1   asynchronous, active-low reset (0 = reset)
//  start      in   1   1-cycle pulse in DONE/ERR: re-arm for a new image
//  in_valid   in   1   byte on in_data valid
//  in_data    in   8   stream byte
//  in_ready   out  1   loader accepts byte this cycle (transfer = in_valid & in_ready)
//  mem_wen    out  1   IMem write enable, active-low (memory convention: 0 = write)
//  mem_addr   out  16  IMem write address
//  mem_wdata  out  16  IMem write data
//  cpu_hold   out  1   1 = CPU PC/IF-ID held; 0 only in DONE
//  done       out  1   image loaded successfully (level)
//  err        out  1   image rejected (level, sticky until start/reset)
// BEHAVIOUR
//  - Reset (rst=0, async): state=LEN_HI, in_ready=1, mem_wen=1, mem_addr=BASE_ADDR, mem_wdata=0,
//    cpu_hold=1, done=0, err=0; word count, index and checksum cleared.
//  - Stream format (big-endian): LEN_HI, LEN_LO (N words), then N x {W_HI, W_LO}, then optional checksum.
//  - FSM: LEN_HI -> LEN_LO -> (N==0 ? CHK_HI/DONE : W_HI) ; W_HI -> W_LO -> WRITE
//    WRITE -> (idx==N ? CHK_HI/DONE : W_HI) ; CHK_HI -> CHK_LO -> DONE|ERR ; DONE/ERR --start--> LEN_HI.
//  - Byte states advance only on a transfer; no transfer = hold state, no side effects.
//  - In_ready is 1 in LEN_*, W_*, CHK_* and 0 in WRITE, DONE and ERR.
//  - WRITE lasts exactly 1 cycle:
//    - mem_wen=0, mem_addr=BASE_ADDR+idx (mod 2^16), mem_wdata={W_HI,W_LO}.
//    - idx increments at the end of the cycle.
//  - Outside WRITE: mem_wen=1; mem_addr/mem_wdata hold their last value.
//  - Latency: write strobe in the cycle after the W_LO transfer; throughput 1 word per 3 cycles minimum.
//  - N > DEPTH detected on the LEN_LO transfer: go to ERR with zero writes, err=1.
//  - N==0: no writes; DONE (or checksum phase when enabled).
//  - cpu_hold=1 in every state except DONE; done=1 only in DONE; err=1 only in ERR.
//  - start ignored outside DONE/ERR. When accepted, clears done/err/idx and re-enters LEN_HI next cycle.
//  - Reset mid-load: immediate abort. A partially written IMem is not cleaned up; the stream restarts at LEN_HI.
//  - BASE_ADDR+idx wraps modulo 2^16 silently.
// CONFIGURATION
//  LOADER_CHKSUM_EN defined:
//    - After the last word, expect CHK_HI, CHK_LO = 16-bit sum of all words, mod 2^16.
//    - Match -> DONE; mismatch -> ERR. Words are already written, but the CPU stays held.
//  LOADER_CHKSUM_EN undefined:
//    - No CHK states and no checksum adder.
//    - The last WRITE (or LEN_LO with N==0) goes straight to DONE.
// TESTING
//  1 Reset:
//    rst=0 mid-stream -> all outputs at reset values within the same cycle (async), cpu_hold=1.
//  2 Basic load:
//    bytes 00 02 12 34 AB CD (checksum off) -> 2 write strobes:
//    addr 0000/1234, then 0001/ABCD; then done=1, cpu_hold=0.
//  3 Backpressure/gaps:
//    in_valid toggled randomly -> identical writes; in_ready=0 during each WRITE cycle; no byte lost.
//  4 Oversize:
//    DEPTH=4, length 00 05 -> err=1, zero mem_wen pulses, in_ready=0, cpu_hold=1; start -> LEN_HI.
//  5 Checksum (LOADER_CHKSUM_EN):
//    00 02 12 34 AB CD BE 01 -> done=1.
//    Same image with 00 00 checksum -> err=1, cpu_hold=1.
//  6 N==0 and wrap:
//    00 00 -> done with no writes.
//    BASE_ADDR=FFFF, N=2 -> writes at FFFF then 0000.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader that writes the instruction memory.
// Takes a big-endian byte stream made of LEN_HI, LEN_LO and then N x {W_HI, W_LO}.
// It assembles 16-bit words and writes each one through an active-low IMem write
// port, holding the CPU until the whole image is in place.
// Optional feature, compile-time macro LOADER_CHKSUM_EN: a trailing 16-bit
// checksum (sum of all words, mod 2^16) must match, otherwise the image is rejected.
module imem_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] DEPTH     = 16'd256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_wen,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_W_HI,
    S_W_LO,
    S_WRITE,
`ifdef LOADER_CHKSUM_EN
    S_CHK_HI,
    S_CHK_LO,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] idx;
  logic [7:0]  word_hi;
`ifdef LOADER_CHKSUM_EN
  logic [15:0] chksum;
  logic [7:0]  chk_hi;
`endif

  logic        xfer;
  logic [15:0] len_in;
  logic [15:0] word_in;
  logic [15:0] idx_inc;

  // Handshake and byte-assembly helpers; in_ready is registered, so xfer is glitch-free.
  assign xfer    = in_valid & in_ready;
  assign len_in  = {len_hi, in_data};
  assign word_in = {word_hi, in_data};
  assign idx_inc = idx + 16'd1;

  // Loader FSM; every output is registered and updated together with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_LEN_HI;
      len_hi    <= 8'd0;
      len       <= 16'd0;
      idx       <= 16'd0;
      word_hi   <= 8'd0;
      in_ready  <= 1'b1;
      mem_wen   <= 1'b1;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= 16'd0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef LOADER_CHKSUM_EN
      chksum    <= 16'd0;
      chk_hi    <= 8'd0;
`endif
    end else begin
      case (state)
        S_LEN_HI: begin
          if (xfer) begin
            len_hi <= in_data;
            state  <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (xfer) begin
            len <= len_in;
            idx <= 16'd0;
            if (len_in > DEPTH) begin
              // Oversized image: reject before any word is written.
              state    <= S_ERR;
              in_ready <= 1'b0;
              err      <= 1'b1;
            end else if (len_in == 16'd0) begin
`ifdef LOADER_CHKSUM_EN
              state    <= S_CHK_HI;
`else
              state    <= S_DONE;
              in_ready <= 1'b0;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
`endif
            end else begin
              state <= S_W_HI;
            end
          end
        end

        S_W_HI: begin
          if (xfer) begin
            word_hi <= in_data;
            state   <= S_W_LO;
          end
        end

        S_W_LO: begin
          if (xfer) begin
            // Strobe is presented in the following cycle (S_WRITE); the stream pauses for it.
            mem_wen   <= 1'b0;
            mem_addr  <= BASE_ADDR + idx;
            mem_wdata <= word_in;
            in_ready  <= 1'b0;
            state     <= S_WRITE;
`ifdef LOADER_CHKSUM_EN
            chksum    <= chksum + word_in;
`endif
          end
        end

        S_WRITE: begin
          mem_wen <= 1'b1;
          idx     <= idx_inc;
          if (idx_inc == len) begin
`ifdef LOADER_CHKSUM_EN
            state    <= S_CHK_HI;
            in_ready <= 1'b1;
`else
            state    <= S_DONE;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
`endif
          end else begin
            state    <= S_W_HI;
            in_ready <= 1'b1;
          end
        end

`ifdef LOADER_CHKSUM_EN
        S_CHK_HI: begin
          if (xfer) begin
            chk_hi <= in_data;
            state  <= S_CHK_LO;
          end
        end

        S_CHK_LO: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if ({chk_hi, in_data} == chksum) begin
              state    <= S_DONE;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else begin
              // Words already sit in IMem, but the CPU stays held.
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
`endif

        S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_LEN_HI;
            in_ready <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            idx      <= 16'd0;
`ifdef LOADER_CHKSUM_EN
            chksum   <= 16'd0;
`endif
          end
        end

        default: begin
          state    <= S_LEN_HI;
          in_ready <= 1'b1;
          mem_wen  <= 1'b1;
          cpu_hold <= 1'b1;
          done     <= 1'b0;
          err      <= 1'b0;
        end
      endcase
    end
  end

endmodule
